// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared constants and lane field-slicing helpers for the
//               inter-stage pipeline register.
//               NOP_IR      - instruction word presented by an empty stage.
//               PIPE_FIELD  - slice lane `lane` of width `width` out of a
//                             packed multi-lane vector.
//               PIPE_PC / PIPE_IR - PIPE_FIELD specialised for the PC and IR
//                             buses (expect PC_BITS / IR_BITS in scope).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef PIPE_PKG_MACROS_SV
`define PIPE_PKG_MACROS_SV
`define PIPE_FIELD(vec, lane, width) vec[(lane)*(width) +: (width)]
`define PIPE_PC(vec, lane) `PIPE_FIELD(vec, lane, PC_BITS)
`define PIPE_IR(vec, lane) `PIPE_FIELD(vec, lane, IR_BITS)
`endif

package pipe_pkg;

    // Instruction word shown on an empty stage (all-zero encoding).
    localparam logic [31:0] NOP_IR = 32'h0000_0000;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_entry_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_entry_slot
// Description : One pipeline entry register {valid, lane_valid, pc, ir}.
//               clr empties the slot; load writes d_* (d_valid=0 empties it,
//               so an emptied slot always shows pc=0 / ir=NOP_IR).
//               clr has priority over load.
// Ports       : clk, rst_n (async, active-low)
//               clr, load                    - control
//               d_valid, d_lane_valid, d_pc, d_ir - write data
//               valid, lane_valid, pc, ir    - stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_slot
    import pipe_pkg::*;
#(
    parameter int PC_BITS = 32,
    parameter int IR_BITS = 32,
    parameter int LANES   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       d_valid,
    input  logic [LANES-1:0]           d_lane_valid,
    input  logic [LANES*PC_BITS-1:0]   d_pc,
    input  logic [LANES*IR_BITS-1:0]   d_ir,
    output logic                       valid,
    output logic [LANES-1:0]           lane_valid,
    output logic [LANES*PC_BITS-1:0]   pc,
    output logic [LANES*IR_BITS-1:0]   ir
);

    localparam logic [LANES*IR_BITS-1:0] c_EMPTY_IR = {LANES{IR_BITS'(NOP_IR)}};

    logic                     r_valid;
    logic [LANES-1:0]         r_lane_valid;
    logic [LANES*PC_BITS-1:0] r_pc;
    logic [LANES*IR_BITS-1:0] r_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_lane_valid <= '0;
            r_pc         <= '0;
            r_ir         <= c_EMPTY_IR;
        end else if (clr || (load && !d_valid)) begin
            r_valid      <= 1'b0;
            r_lane_valid <= '0;
            r_pc         <= '0;
            r_ir         <= c_EMPTY_IR;
        end else if (load) begin
            r_valid      <= 1'b1;
            r_lane_valid <= d_lane_valid;
            r_pc         <= d_pc;
            r_ir         <= d_ir;
        end
    end

    assign valid      = r_valid;
    assign lane_valid = r_lane_valid;
    assign pc         = r_pc;
    assign ir         = r_ir;

endmodule : pipe_entry_slot

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register carrying LANES x {PC, IR,
//               lane-valid} with valid/ready handshake, stall hold, flush,
//               bubble dropping and a saturating stall-cycle counter.
//               Build option PIPE_SKID_EN: adds a skid entry so that in_ready
//               comes straight from a flop (no out_ready -> in_ready path).
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready, in_lane_valid, in_pc, in_ir - upstream
//               flush, stall                                   - control
//               out_valid/out_ready, out_lane_valid, out_pc, out_ir - downstream
//               stall_cnt                                      - perf counter
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_BITS        = 32,
    parameter int IR_BITS        = 32,
    parameter int LANES          = 1,
    parameter int STALL_CNT_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            in_lane_valid,
    input  logic [LANES*PC_BITS-1:0]    in_pc,
    input  logic [LANES*IR_BITS-1:0]    in_ir,
    input  logic                        flush,
    input  logic                        stall,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            out_lane_valid,
    output logic [LANES*PC_BITS-1:0]    out_pc,
    output logic [LANES*IR_BITS-1:0]    out_ir,
    output logic [STALL_CNT_BITS-1:0]   stall_cnt
);

    // Main slot view
    logic                     w_main_valid;
    logic [LANES-1:0]         w_main_lane_valid;
    logic [LANES*PC_BITS-1:0] w_main_pc;
    logic [LANES*IR_BITS-1:0] w_main_ir;

    // Main slot write port
    logic                     w_main_load;
    logic                     w_main_d_valid;
    logic [LANES-1:0]         w_main_d_lane_valid;
    logic [LANES*PC_BITS-1:0] w_main_d_pc;
    logic [LANES*IR_BITS-1:0] w_main_d_ir;

    logic w_accept;
    logic w_keep;
    logic w_handoff;

    logic [STALL_CNT_BITS-1:0] r_stall_cnt;
    logic                      w_stall_evt;

    assign w_accept  = in_valid & in_ready;
    // An all-lanes-invalid entry is a bubble: consumed but never stored.
    assign w_keep    = w_accept & (|in_lane_valid);
    assign out_valid = w_main_valid & ~stall;
    assign w_handoff = out_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic                     w_skid_valid;
    logic [LANES-1:0]         w_skid_lane_valid;
    logic [LANES*PC_BITS-1:0] w_skid_pc;
    logic [LANES*IR_BITS-1:0] w_skid_ir;
    logic                     w_skid_load;
    logic                     w_main_take;

    // in_ready depends only on stall and a flop: out_ready never reaches it.
    assign in_ready = ~stall & ~w_skid_valid;

    // Main refills whenever it is empty or its entry leaves this cycle.
    assign w_main_take = ~w_main_valid | w_handoff;
    assign w_main_load = ~stall & w_main_take;

    // Skid holds the older entry, so it feeds main before any new input.
    always_comb begin
        w_main_d_valid      = w_keep;
        w_main_d_lane_valid = in_lane_valid;
        w_main_d_pc         = in_pc;
        w_main_d_ir         = in_ir;
        if (w_skid_valid) begin
            w_main_d_valid      = 1'b1;
            w_main_d_lane_valid = w_skid_lane_valid;
            w_main_d_pc         = w_skid_pc;
            w_main_d_ir         = w_skid_ir;
        end
    end

    // Skid is rewritten when its entry moves to main (refilled by any
    // same-cycle accept, else emptied) or when an accept meets a full,
    // non-draining main.
    assign w_skid_load = ~stall & ((w_main_take & w_skid_valid) |
                                   (~w_main_take & w_keep));

    pipe_entry_slot #(
        .PC_BITS (PC_BITS),
        .IR_BITS (IR_BITS),
        .LANES   (LANES)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (flush),
        .load         (w_skid_load),
        .d_valid      (w_keep),
        .d_lane_valid (in_lane_valid),
        .d_pc         (in_pc),
        .d_ir         (in_ir),
        .valid        (w_skid_valid),
        .lane_valid   (w_skid_lane_valid),
        .pc           (w_skid_pc),
        .ir           (w_skid_ir)
    );
`else
    // Single slot: accept when empty or when the held entry leaves now.
    assign in_ready = ~stall & (~w_main_valid | out_ready);

    // Load on a new entry (replaces a departing one with no gap) or on a
    // hand-off with nothing arriving (empties the slot).
    assign w_main_load         = ~stall & (w_keep | w_handoff);
    assign w_main_d_valid      = w_keep;
    assign w_main_d_lane_valid = in_lane_valid;
    assign w_main_d_pc         = in_pc;
    assign w_main_d_ir         = in_ir;
`endif

    pipe_entry_slot #(
        .PC_BITS (PC_BITS),
        .IR_BITS (IR_BITS),
        .LANES   (LANES)
    ) u_main (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (flush),
        .load         (w_main_load),
        .d_valid      (w_main_d_valid),
        .d_lane_valid (w_main_d_lane_valid),
        .d_pc         (w_main_d_pc),
        .d_ir         (w_main_d_ir),
        .valid        (w_main_valid),
        .lane_valid   (w_main_lane_valid),
        .pc           (w_main_pc),
        .ir           (w_main_ir)
    );

    assign out_lane_valid = w_main_lane_valid;
    assign out_pc         = w_main_pc;
    assign out_ir         = w_main_ir;

    // Counts cycles where the stage is frozen or its entry is back-pressured.
    // Only reset clears it; flush leaves it alone.
    assign w_stall_evt = stall | (w_main_valid & ~out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != {STALL_CNT_BITS{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (LANES=2, 4-bit
//               stall counter). A queue model of held entries predicts every
//               output each cycle; directed literal checks pin key values.
//               Works for both the default build and PIPE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int c_LANES = 2;
    localparam int c_CNTW  = 4;
    localparam int c_CMAX  = 15;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_lane_valid;
    logic [63:0]          in_pc;
    logic [63:0]          in_ir;
    logic                 flush;
    logic                 stall;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_lane_valid;
    logic [63:0]          out_pc;
    logic [63:0]          out_ir;
    logic [c_CNTW-1:0]    stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(
        .PC_BITS        (32),
        .IR_BITS        (32),
        .LANES          (c_LANES),
        .STALL_CNT_BITS (c_CNTW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_pc          (in_pc),
        .in_ir          (in_ir),
        .flush          (flush),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_pc         (out_pc),
        .out_ir         (out_ir),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0]  lv;
        logic [63:0] pc;
        logic [63:0] ir;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;
    bit   m_acc;
    bit   m_ho;

    function automatic bit exp_in_ready();
`ifdef PIPE_SKID_EN
        return !stall && (q.size() < 2);
`else
        return !stall && (q.size() == 0 || out_ready);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
        end else begin
            m_acc = in_valid && exp_in_ready();
            m_ho  = (q.size() > 0) && !stall && out_ready;
            if ((stall || (q.size() > 0 && !out_ready)) && m_cnt < c_CMAX)
                m_cnt++;
            if (flush) begin
                q.delete();
            end else if (!stall) begin
                if (m_ho) void'(q.pop_front());
                if (m_acc && in_lane_valid != 2'b00)
                    q.push_back('{lv: in_lane_valid, pc: in_pc, ir: in_ir});
            end
        end
    end

    // Compare process: every cycle out of reset, at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_out_valid", 64'(out_valid), 64'((q.size() > 0) && !stall));
            chk("m_in_ready",  64'(in_ready),  64'(exp_in_ready()));
            chk("m_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
            if (q.size() > 0) begin
                chk("m_out_pc",   out_pc,              q[0].pc);
                chk("m_out_ir",   out_ir,              q[0].ir);
                chk("m_lane_vld", 64'(out_lane_valid), 64'(q[0].lv));
            end else begin
                chk("m_out_pc",   out_pc,              64'h0);
                chk("m_out_ir",   out_ir,              64'h0);
                chk("m_lane_vld", 64'(out_lane_valid), 64'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_lane_valid = 2'b00;
        in_pc         = 64'h0;
        in_ir         = 64'h0;
        flush         = 1'b0;
        stall         = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc);
        in_valid      = 1'b1;
        in_lane_valid = 2'b01;
        in_pc         = {32'h0, pc};
        in_ir         = {32'h0, 32'h1300_0000 | pc};
    endtask

    bit seen_20;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_ir",    out_ir,         64'h0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Stream 0,4,8,C with out_ready=1: one per cycle, 1-cycle latency.
        drive(32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(32'(4 * (i + 1)));
            else       idle();
            @(negedge clk);
            chk("t2_valid", 64'(out_valid), 64'h1);
            chk("t2_pc",    out_pc,         64'(4 * i));
            step();
        end

        // Reset mid-stream while main holds 0x40.
        out_ready = 1'b0;
        drive(32'h40);
        step();
        idle();
        step();
        @(negedge clk);
        chk("t1_pc_held",  out_pc,         64'h40);
        chk("t1_cnt_pre",  64'(stall_cnt), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'h0);
        chk("t1_out_ir",    out_ir,         64'h0);
        chk("t1_stall_cnt", 64'(stall_cnt), 64'h0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // Stall for 3 cycles with 0x10 held.
        drive(32'h10);
        step();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_in_ready",  64'(in_ready),  64'h0);
            chk("t3_out_valid", 64'(out_valid), 64'h0);
            chk("t3_pc",        out_pc,         64'h10);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("t3_stall_cnt", 64'(stall_cnt), 64'h3);
        chk("t3_release",   64'(out_valid), 64'h1);
        step();

        // Flush with 0x20 arriving while 0x1C is held.
        drive(32'h1C);
        step();
        drive(32'h20);
        flush = 1'b1;
        step();
        idle();
        @(negedge clk);
        chk("t4_out_valid", 64'(out_valid), 64'h0);
        chk("t4_out_ir",    out_ir,         64'h0);
        seen_20 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            if (out_valid && out_pc[31:0] == 32'h20) seen_20 = 1'b1;
        end
        chk("t4_no_0x20", 64'(seen_20), 64'h0);

        // Bubble drop, then lane 1 only.
        in_valid      = 1'b1;
        in_lane_valid = 2'b00;
        in_pc         = 64'h0000_0200_0000_0200;
        in_ir         = 64'h1;
        step();
        idle();
        @(negedge clk);
        chk("t5_bubble", 64'(out_valid), 64'h0);
        in_valid      = 1'b1;
        in_lane_valid = 2'b10;
        in_pc         = {32'h104, 32'h100};
        in_ir         = {32'hAAAA_0001, 32'hBBBB_0002};
        step();
        idle();
        @(negedge clk);
        chk("t5_lane_valid", 64'(out_lane_valid), 64'h2);
        chk("t5_pc",         out_pc,              64'h0000_0104_0000_0100);
        chk("t5_valid",      64'(out_valid),      64'h1);
        step();

        // Back-pressure: skid build holds two entries, default build one.
        out_ready = 1'b0;
        drive(32'h0);
        step();
`ifdef PIPE_SKID_EN
        drive(32'h4);
        @(negedge clk);
        chk("t6_ready_2nd", 64'(in_ready), 64'h1);
        step();
        idle();
        @(negedge clk);
        chk("t6_ready_3rd", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_ready_comb", 64'(in_ready), 64'h0);
        chk("t6_first",      out_pc,        64'h0);
        step();
        @(negedge clk);
        chk("t6_second",     out_pc,        64'h4);
        chk("t6_ready_back", 64'(in_ready), 64'h1);
        step();
`else
        idle();
        @(negedge clk);
        chk("t6_ready_full", 64'(in_ready), 64'h0);
        step();
        out_ready = 1'b1;
        #1;
        chk("t6_ready_comb", 64'(in_ready), 64'h1);
        @(negedge clk);
        chk("t6_first", out_pc, 64'h0);
        step();
`endif

        // Mixed traffic: stall, flush, back-pressure and bubbles together.
        for (int i = 0; i < 60; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_lane_valid = 2'($urandom_range(0, 3));
            in_pc         = {32'h0, 32'(16'h1000 + 4 * i)};
            in_ir         = {32'($urandom), 32'($urandom)};
            stall         = ($urandom_range(0, 5) == 0);
            flush         = ($urandom_range(0, 11) == 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            step();
        end
        idle();
        out_ready = 1'b1;
        step();

        // Counter saturates at all-ones and survives a flush.
        stall = 1'b1;
        repeat (20) step();
        flush = 1'b1;
        step();
        idle();
        @(negedge clk);
        chk("t7_saturate", 64'(stall_cnt), 64'hF);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg

`default_nettype wire
